pipelined_barrel_shifter: RTL
=============================

# pipelined_barrel_shifter

Parametrised, pipelined variable-amount shifter with valid/ready flow control. It generalises the fixed-distance shift blocks to a run-time shift amount with four selectable modes: logical left, logical right, arithmetic right and rotate right. There is one log-shifter stage per shift-amount bit, each followed by a register. It sits in the arithmetic datapath between an argument producer and a result consumer, and accepts one argument per cycle with full backpressure.

## Interface
- `N`, default 8: data width. Must be a power of two, ≥ 2.
- `SW`, default `$clog2(N)`: shift-amount width. Derived; not to be overridden.
- `L`, default `SW`: pipeline depth in stages. Derived.
- `clk` input 1: clock. Single clock domain.
- `rst` input 1: synchronous, active-high reset.
- `arg_vld` input 1: argument valid.
- `arg_rdy` output 1: shifter can accept an argument this cycle.
- `a` input N: data operand (unsigned, except in ASR mode).
- `sh` input SW: shift amount, 0..N-1.
- `mode` input 2: 00 LSL, 01 LSR, 10 ASR (sign bit `a[N-1]` replicated), 11 ROR.
- `res_vld` output 1: result valid.
- `res_rdy` input 1: consumer accepts the result.
- `res` output N: shifted result.

## Operation
- **Transfer rule:** a transfer occurs on an edge where `vld && rdy` are both high. `arg_vld` must not depend on `arg_rdy`.
- **Stage k (k = 0..L-1):** shifts by 2^k if captured `sh[k]` is 1, otherwise passes data through.
  - Each stage register holds: valid bit, N-bit data, the remaining upper shift bits, and mode.
- **Per-mode fill for a stage shift of d = 2^k:**
  - LSL: d zeros enter at the LSB end.
  - LSR: d zeros enter at the MSB end.
  - ASR: d copies of the original sign bit enter at the MSB. The sign is captured at stage 0 and carried with the operand.
  - ROR: bits shifted out at the LSB re-enter at the MSB.
- **Result:** composing all stages gives the exact shift by `sh`. `sh = 0` returns `a` unchanged in every mode.
- **Stall logic (stage k):**
  - `adv[k] = !v[k] || adv[k+1]`, with `adv[L] = res_rdy`.
  - A stage register loads when `adv[k]` is 1. Otherwise it holds data and valid.
  - `arg_rdy = adv[0]`. This is a combinational path from `res_rdy`, and that path is allowed.
- **Bubbles:** a stage that loads with its upstream invalid clears its valid bit. Bubbles do not block advance.
- **Outputs:** `res` and `res_vld` are the last stage register's data and valid.
  - `res` must remain stable while `res_vld && !res_rdy`.
- **Ordering:** results leave in acceptance order. No reordering, no drop, no duplication.
- **Capacity:** L results in flight. With `res_rdy` low and the pipe full, `arg_rdy = 0`.
- **Reset:** all valid bits clear and all data registers become 0, so `res_vld = 0` and `res = 0`. `arg_rdy = 1` in the first cycle after reset.
  - Reset mid-operation discards every in-flight item. No result from before the reset may appear afterwards.
- **Simultaneous events:**
  - Pipe full, `res_rdy = 1` and `arg_vld = 1` in the same cycle: one result leaves, one argument enters, throughput is maintained.
  - `rst` overrides all handshakes.

## Timing
- **Latency:** an argument transferred in cycle c has `res_vld = 1` in cycle c+L, provided there are no stalls. For N=8, L=3.
- **Throughput:** 1 result per cycle while `res_rdy` stays high.
- **Stall:** each cycle of `res_rdy = 0` with a full pipe delays every in-flight result by exactly 1 cycle.
- **Critical path:** one 2:1 mux level plus fill logic per stage. The ready chain is L AND/OR levels.
- **Registered outputs:** `res` and `res_vld` are driven directly from flops. `arg_rdy` is combinational.

## Test plan
All scenarios use N=8.

- **Modes:** `a = 8'hB6`, `sh = 3`, `res_rdy = 1`, mode 00/01/10/11 back-to-back → `res` = `8'hB0`, `8'h16`, `8'hF6`, `8'hD6` on consecutive cycles. The first result arrives 3 cycles after acceptance.
- **Boundary amounts:** `a = 8'h81`, `sh = 0` → `8'h81` in all modes. `sh = 7`: LSL → `8'h80`, LSR → `8'h01`, ASR → `8'hFF`, ROR → `8'h03`. `a = 8'h7F`, ASR, `sh = 7` → `8'h00`.
- **Backpressure:** stream 8 arguments of `a = i`, LSL, `sh = 1`, holding `res_rdy = 0`.
  - After 3 accepted, `arg_rdy = 0` and `res` holds `8'h00` stable.
  - Release `res_rdy` → outputs `8'h00, 02, 04, … 0E` in order, one per cycle, none lost.
- **Bubbles:** `arg_vld` toggling 1,0,1,0 with `res_rdy = 1` → `res_vld` shows the same pattern delayed by 3 cycles.
- **Reset mid-flight:** accept 3 items, then assert `rst` for 1 cycle → `res_vld = 0` in the next cycle and stays 0 until new arguments are accepted. `arg_rdy = 1` after reset.
- **Random:** 10k random `a`/`sh`/`mode` with random `arg_vld`/`res_rdy` → scoreboard compares against the reference model (`<<`, `>>`, `>>>` on a signed value, and rotate), in order.

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined log shifter: one register stage per shift-amount bit, with a
// valid/ready stall chain so a full pipe backpressures the producer.
module pipelined_barrel_shifter #(
    parameter int N  = 8,
    parameter int SW = $clog2(N),
    parameter int L  = SW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arg_vld,
    output logic          arg_rdy,
    input  logic [N-1:0]  a,
    input  logic [SW-1:0] sh,
    input  logic [1:0]    mode,
    output logic          res_vld,
    input  logic          res_rdy,
    output logic [N-1:0]  res
);
    logic [L:0]             adv;
    logic [L-1:0]           vld_pipe;
    logic [L-1:0]           v_in;
    logic [L-1:0][N-1:0]    d_in;
    logic [L-1:0][N-1:0]    d_q;
    logic [L-1:0][SW-1:0]   sh_in;
    logic [L-1:0][1:0]      md_in;
    logic [L-1:0]           sg_in;

    assign adv[L]   = res_rdy;
    assign arg_rdy  = adv[0];
    assign v_in[0]  = arg_vld;
    assign d_in[0]  = a;
    assign sh_in[0] = sh;
    assign md_in[0] = mode;
    // ASR fill comes from the original operand's sign, not the shifted data
    assign sg_in[0] = a[N-1];
    assign res_vld  = vld_pipe[L-1];
    assign res      = d_q[L-1];

    for (genvar k = 0; k < L; k++) begin : g_stg
        localparam int D = 1 << k;
        localparam logic [N-1:0] FILL = ~({N{1'b1}} >> D);

        logic [N-1:0] shf;
        logic         vld_r;
        logic [N-1:0] dat_r;

        assign adv[k]      = !vld_r || adv[k+1];
        assign vld_pipe[k] = vld_r;
        assign d_q[k]      = dat_r;

        always_comb begin
            shf = d_in[k];
            if (sh_in[k][0]) begin
                unique case (md_in[k])
                    2'd0:    shf = d_in[k] << D;
                    2'd1:    shf = d_in[k] >> D;
                    2'd2:    shf = (d_in[k] >> D) | (sg_in[k] ? FILL : '0);
                    default: shf = (d_in[k] >> D) | (d_in[k] << (N - D));
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_r <= 1'b0;
                dat_r <= '0;
            end else if (adv[k]) begin
                vld_r <= v_in[k];
                dat_r <= shf;
            end
        end

        // Control sidebands only travel as far as a later stage needs them
        if (k < L-1) begin : g_meta
            logic [SW-1:0] sh_r;
            logic [1:0]    md_r;
            logic          sg_r;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sh_r <= '0;
                    md_r <= '0;
                    sg_r <= 1'b0;
                end else if (adv[k]) begin
                    sh_r <= sh_in[k] >> 1;
                    md_r <= md_in[k];
                    sg_r <= sg_in[k];
                end
            end

            assign v_in[k+1]  = vld_pipe[k];
            assign d_in[k+1]  = d_q[k];
            assign sh_in[k+1] = sh_r;
            assign md_in[k+1] = md_r;
            assign sg_in[k+1] = sg_r;
        end
    end
endmodule
